// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_CLR  = 3'b100;
    localparam logic [2:0] USR_ROR  = 3'b101;
    localparam logic [2:0] USR_ROL  = 3'b110;
    localparam logic [2:0] USR_RSVD = 3'b111;

endpackage

// File: rtl/dff_sr.sv
// Single-bit D flip-flop with synchronous active-high reset.
module dff_sr (
    input  logic clock,
    input  logic reset,
    input  logic D,
    output logic Q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/load/clear, optional rotate (USR_ROTATE_EN),
// and a strobe after every WIDTH counted shift operations.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             shift_done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] q_d, q_q;
    logic [CntW-1:0]  cnt_d, cnt_q;
    logic             done_d, done_q;
    logic             is_shift, clr_cnt;

    always_comb begin
        q_d      = q_q;
        is_shift = 1'b0;
        clr_cnt  = 1'b0;
        case (mode)
            USR_SHR: begin
                q_d      = {sin_r, q_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            USR_SHL: begin
                q_d      = {q_q[WIDTH-2:0], sin_l};
                is_shift = 1'b1;
            end
            USR_LOAD: begin
                q_d     = d;
                clr_cnt = 1'b1;
            end
            USR_CLR: begin
                q_d     = '0;
                clr_cnt = 1'b1;
            end
`ifdef USR_ROTATE_EN
            USR_ROR: begin
                q_d      = {q_q[0], q_q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            USR_ROL: begin
                q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                is_shift = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Counter wraps on the WIDTH-th shift, raising the strobe for the following cycle.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (is_shift) begin
            if (cnt_q == CntLast) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        dff_sr u_dff (
            .clock (clock),
            .reset (reset),
            .D     (q_d[i]),
            .Q     (q_q[i])
        );
    end

    assign q          = q_q;
    assign sout_r     = q_q[0];
    assign sout_l     = q_q[WIDTH-1];
    assign shift_done = done_q;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, register width in bits (legal range 2..64).
REQ-002 SHALL have port: clock  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: mode  input  3  operation select, sampled every rising edge.
REQ-005 SHALL have port: d  input  WIDTH  parallel load data.
REQ-006 SHALL have port: sin_r  input  1  serial input, enters at MSB on shift right.
REQ-007 SHALL have port: sin_l  input  1  serial input, enters at LSB on shift left.
REQ-008 SHALL have port: q  output  WIDTH  register contents.
REQ-009 SHALL have port: sout_r  output  1  combinational q[0].
REQ-010 SHALL have port: sout_l  output  1  combinational q[WIDTH-1].
REQ-011 SHALL have port: shift_done  output  1  registered one-cycle strobe on completing WIDTH consecutive shifts.

Function
REQ-012 SHALL decode mode as: 000 hold; 001 shift right, q <= {sin_r, q[W-1:1]}; 010 shift left, q <= {q[W-2:0], sin_l}; 011 load, q <= d; 100 clear, q <= 0; 101 rotate right; 110 rotate left; 111 reserved, treated as hold.
REQ-013 SHALL update q one clock after mode/d/sin sampling; latency exactly 1 cycle, no combinational path from inputs to q.
REQ-014 SHALL keep a shift counter, width $clog2(WIDTH+1), incremented on every shift or rotate operation (modes 001, 010, 101, 110).
REQ-015 SHALL clear the counter on load, clear, or reset; hold and reserved modes leave it unchanged (shifts need not be back-to-back).
REQ-016 SHALL, on the edge applying the counter's WIDTH-th shift, drive shift_done high for exactly that following cycle and wrap the counter to 0 on the same edge.
REQ-017 SHALL count mixed shift directions together (left and right both increment).
REQ-018 SHALL deassert shift_done in every cycle not covered by REQ-016.
REQ-019 SHALL give reset priority over every mode value.

Reset
REQ-020 SHALL, on rising clock edge with reset=1, set q=0, counter=0, shift_done=0; sout_r/sout_l follow q (0).
REQ-021 SHALL abort an in-progress shift sequence on reset; the next shift after reset counts as 1.

Configuration
REQ-022 SHALL compile rotate support only when macro USR_ROTATE_EN is defined: 101 rotates right (q <= {q[0], q[W-1:1]}), 110 rotates left (q <= {q[W-2:0], q[W-1]}), both counted.
REQ-023 SHALL, without USR_ROTATE_EN, treat 101 and 110 as hold (q and counter unchanged, no shift_done).

Structure
REQ-024 SHALL place mode encodings (USR_HOLD, USR_SHR, USR_SHL, USR_LOAD, USR_CLR, USR_ROR, USR_ROL) in shared package usr_pkg.
REQ-025 SHALL build q from WIDTH instances of sub-module dff_sr (1-bit D flip-flop, sync active-high reset, ports clock, reset, D, Q), next-state mux in the parent.
REQ-026 SHALL implement counter and shift_done in universal_shift_reg, not in dff_sr.

Verification (WIDTH=8)
REQ-027 SHALL cover: reset held 2 cycles, then mode=011 d=0xA5 -> q=0xA5 next cycle, shift_done=0.
REQ-028 SHALL cover: q=0xA5, mode=001 sin_r=1 -> q=0xD2; sout_r was 1 before the edge, 0 after.
REQ-029 SHALL cover: load 0xFF, then 8 cycles mode=010 sin_l=0 with one hold cycle inserted after the 4th -> q=0x00, shift_done high only in the cycle after the 8th shift.
REQ-030 SHALL cover: USR_ROTATE_EN defined, q=0x81, mode=110 -> q=0x03; undefined, same stimulus -> q=0x81.
REQ-031 SHALL cover: 5 shifts then reset=1 with mode=011 -> q=0x00, shift_done=0; then 8 shifts -> shift_done after the 8th, not the 3rd.
REQ-032 SHALL cover: q=0x3C, mode=111 for 3 cycles -> q=0x3C, counter unchanged, shift_done=0.
